operand_loader: RTL

Upstream feeder for the 4-operand `circuit` datapath. Accepts a byte stream over a valid/ready handshake and assembles four operands `a`, `b`, `c`, `d` plus a `mode` bit. Issues a one-cycle `start` and holds the operands stable until `circuit` raises `done` or a timeout expires. Presents the captured result `i` on a valid/ready result port.

---
 rtl/operand_loader_if.sv | 21 ++
 rtl/operand_loader.sv | 117 +++++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// Byte-stream input channel and result output channel of the operand loader.
interface operand_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_mode;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       res_timeout;

    modport slave (
        input  in_valid, in_data, in_mode, res_ready,
        output in_ready, res_valid, res_data, res_timeout
    );

    modport master (
        output in_valid, in_data, in_mode, res_ready,
        input  in_ready, res_valid, res_data, res_timeout
    );
endinterface

// File: rtl/operand_loader.sv
// Assembles four operand bytes plus a mode bit, launches the 4-operand datapath,
// and returns its result (or a timeout marker) over a valid/ready port.
module operand_loader #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    operand_loader_if.slave        bus,
    output logic [7:0]             a,
    output logic [7:0]             b,
    output logic [7:0]             c,
    output logic [7:0]             d,
    output logic                   mode,
    output logic                   start,
    input  logic                   done,
    input  logic [7:0]             i,
    output logic                   busy
);
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned TIMER_W = 8;
    localparam int unsigned CNT_W   = 2;

    typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT, S_HOLD} state_t;

    state_t               state;
    state_t               next_state;
    logic [CNT_W-1:0]     cnt;
    logic [TIMER_W-1:0]   timer;
    logic [DATA_W-1:0]    res_data_q;
    logic                 res_timeout_q;
    logic                 timeout_hit;

    assign timeout_hit     = (timer == TIMER_W'(TIMEOUT_CYCLES - 1));
    assign bus.res_data    = res_data_q;
    assign bus.res_timeout = res_timeout_q;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_LOAD;
        else       state <= next_state;
    end

    // Next-state and state-decoded handshake outputs
    always_comb begin
        next_state    = state;
        bus.in_ready  = 1'b0;
        bus.res_valid = 1'b0;
        start         = 1'b0;
        busy          = 1'b0;
        case (state)
            S_LOAD: begin
                bus.in_ready = ~reset;
                if (bus.in_valid && (cnt == CNT_W'(3))) next_state = S_FIRE;
            end
            S_FIRE: begin
                start      = 1'b1;
                busy       = 1'b1;
                next_state = S_WAIT;
            end
            S_WAIT: begin
                busy = 1'b1;
                if (done || timeout_hit) next_state = S_HOLD;
            end
            S_HOLD: begin
                busy          = 1'b1;
                bus.res_valid = 1'b1;
                if (bus.res_ready) next_state = S_LOAD;
            end
            default: next_state = S_LOAD;
        endcase
    end

    // Operand capture, WAIT timer and result capture; done wins over timeout
    always_ff @(posedge clk) begin
        if (reset) begin
            a             <= '0;
            b             <= '0;
            c             <= '0;
            d             <= '0;
            mode          <= 1'b0;
            cnt           <= '0;
            timer         <= '0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            case (state)
                S_LOAD: begin
                    if (bus.in_valid) begin
                        case (cnt)
                            2'd0: a <= bus.in_data;
                            2'd1: b <= bus.in_data;
                            2'd2: c <= bus.in_data;
                            default: begin
                                d    <= bus.in_data;
                                mode <= bus.in_mode;
                            end
                        endcase
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_FIRE: timer <= '0;
                S_WAIT: begin
                    if (done) begin
                        res_data_q    <= i;
                        res_timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        res_data_q    <= '0;
                        res_timeout_q <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
